// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin sharing of one data-memory port among cores.
// One transaction in flight; read data returned in per-core registered slots.
module rr_mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int CORE_NUM   = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CORE_NUM-1:0]       request,
    input  logic [CORE_NUM-1:0]       wren_core,
    input  logic [CORE_NUM*WIDTH-1:0] address_in,
    input  logic [CORE_NUM*WIDTH-1:0] data_in,
    output logic [CORE_NUM*WIDTH-1:0] data_out,
    output logic [CORE_NUM-1:0]       response,
    output logic [WIDTH-1:0]          address,
    output logic [WIDTH-1:0]          data_write,
    output logic                      wren,
    input  logic [WIDTH-1:0]          data_read,
    output logic                      busy
);

    localparam int PW = $clog2(CORE_NUM);
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [CORE_NUM-1:0] ONE = CORE_NUM'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       cur;
    logic [CORE_NUM-1:0] mask;
    logic [CW-1:0]       cnt;

    logic [CORE_NUM-1:0] eligible;
    logic [PW-1:0]       gnt_idx;
    logic                gnt_found;
    logic [PW:0]         k;
    logic [PW-1:0]       ptr_next;

    // Rotating scan from ptr picks the first eligible requester.
    always_comb begin
        eligible  = request & ~mask;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        k         = '0;
        for (int i = 0; i < CORE_NUM; i++) begin
            k = {1'b0, ptr} + (PW+1)'(i);
            if (k >= (PW+1)'(CORE_NUM)) begin
                k = k - (PW+1)'(CORE_NUM);
            end
            if (!gnt_found && eligible[k[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = k[PW-1:0];
            end
        end
    end

    // Priority moves to the core after the one just served.
    always_comb begin
        if (cur == PW'(CORE_NUM - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cur + PW'(1);
        end
    end

    // Transaction FSM; all memory and core outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cur        <= '0;
            mask       <= '0;
            cnt        <= '0;
            address    <= '0;
            data_write <= '0;
            wren       <= 1'b0;
            response   <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mask <= '0;
                    if (gnt_found) begin
                        cur        <= gnt_idx;
                        address    <= address_in[gnt_idx*WIDTH +: WIDTH];
                        data_write <= data_in[gnt_idx*WIDTH +: WIDTH];
                        wren       <= wren_core[gnt_idx];
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wren <= 1'b0;
                    if (wren) begin
                        response <= ONE << cur;
                        state    <= RESP;
                    end else begin
                        cnt   <= CW'(RD_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        data_out[cur*WIDTH +: WIDTH] <= data_read;
                        response <= ONE << cur;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    response <= '0;
                    ptr      <= ptr_next;
                    mask     <= ONE << cur;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// tb_rr_mem_arbiter: vector table plus scoreboard bench for rr_mem_arbiter.
// Memory model returns a function of the address two cycles after it appears.
module tb_rr_mem_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int RL = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   request;
    logic [N-1:0]   wren_core;
    logic [N*W-1:0] address_in;
    logic [N*W-1:0] data_in;
    logic [N*W-1:0] data_out;
    logic [N-1:0]   response;
    logic [W-1:0]   address;
    logic [W-1:0]   data_write;
    logic           wren;
    logic [W-1:0]   data_read;
    logic           busy;

    rr_mem_arbiter #(
        .WIDTH      (W),
        .CORE_NUM   (N),
        .RD_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .wren_core  (wren_core),
        .address_in (address_in),
        .data_in    (data_in),
        .data_out   (data_out),
        .response   (response),
        .address    (address),
        .data_write (data_write),
        .wren       (wren),
        .data_read  (data_read),
        .busy       (busy)
    );

    typedef struct {
        int          core;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int          core;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_dout;
    } vec_t;

    int          total;
    int          bad;
    int          cyc;
    int          wren_cnt;
    logic [3:0]  hold;
    logic [31:0] model_dout [N];
    txn_t        exp_q [$];
    int          resp_cores [$];
    int          resp_cyc [$];
    vec_t        vecs [6];
    logic [31:0] d1;
    logic [31:0] d2;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return ~a;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= mem_f(address);
        d2 <= d1;
    end
    assign data_read = d2;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic observe();
        txn_t       e;
        logic [3:0] one;
        one = 4'd1;
        if (!rst_n) return;
        if (wren) begin
            if (exp_q.size() == 0) begin
                chk("wren_spurious", 1, 0);
            end else begin
                chk("wren_is_write", exp_q[0].wr, 1);
                chk("wr_addr", address, exp_q[0].addr);
                chk("wr_data", data_write, exp_q[0].data);
            end
            wren_cnt++;
        end
        if (response != 0) begin
            if (exp_q.size() == 0) begin
                chk("resp_spurious", response, 0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_core", response, one << e.core);
                chk("wren_count", wren_cnt, e.wr ? 1 : 0);
                chk("busy_in_resp", busy, 1);
                if (!e.wr) model_dout[e.core] = mem_f(e.addr);
                for (int i = 0; i < N; i++) begin
                    chk("dout_slot", data_out[i*W +: W], model_dout[i]);
                end
                if (!hold[e.core]) request[e.core] = 1'b0;
                resp_cores.push_back(e.core);
                resp_cyc.push_back(cyc);
            end
            wren_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic set_op(input int c, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        wren_core[c]         = w;
        address_in[c*W +: W] = a;
        data_in[c*W +: W]    = d;
        t.core = c;
        t.wr   = w;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_resp(input int n, input int budget);
        int t;
        t = 0;
        while (resp_cores.size() < n && t < budget) begin
            tick();
            t++;
        end
        total++;
        if (resp_cores.size() < n) begin
            bad++;
            $display("FAIL resp_timeout: got %0d want %0d",
                     resp_cores.size(), n);
        end
    endtask

    task automatic clear_log();
        resp_cores.delete();
        resp_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_wren"}, wren, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_resp"}, response, 0);
        chk({nm, "_dout"}, data_out, 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst");
        chk("rst_addr", address, 0);
        chk("rst_wdata", data_write, 0);
        exp_q.delete();
        clear_log();
        for (int i = 0; i < N; i++) model_dout[i] = '0;
        request  = '0;
        hold     = '0;
        wren_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int start;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        wren_cnt   = 0;
        hold       = '0;
        rst_n      = 1'b0;
        request    = '0;
        wren_core  = '0;
        address_in = '0;
        data_in    = '0;
        for (int i = 0; i < N; i++) model_dout[i] = '0;

        vecs[0] = '{2, 1'b0, 32'h40,  32'h0,        4, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 32'h100, 32'h55,       2, 32'h0};
        vecs[2] = '{0, 1'b0, 32'h8,   32'h0,        4, 32'hFFFFFFF7};
        vecs[3] = '{3, 1'b1, 32'h200, 32'h12345678, 2, 32'h0};
        vecs[4] = '{1, 1'b0, 32'h44,  32'h0,        4, 32'hFFFFFFBB};
        vecs[5] = '{3, 1'b0, 32'h10,  32'h0,        4, 32'hFFFFFFEF};

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("init");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            clear_log();
            set_op(vecs[v].core, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            start = cyc;
            request[vecs[v].core] = 1'b1;
            wait_resp(1, 20);
            if (resp_cyc.size() > 0) begin
                chk("vec_latency", resp_cyc[0] - start, vecs[v].exp_lat);
            end
            if (!vecs[v].wr) begin
                chk("vec_dout", data_out[vecs[v].core*W +: W],
                    vecs[v].exp_dout);
            end
            tick();
            chk("vec_busy_after", busy, 0);
            tick();
        end

        clear_log();
        set_op(3, 1'b0, 32'h70, 32'h0);
        request[3] = 1'b1;
        tick();
        request[3] = 1'b0;
        wait_resp(1, 20);
        repeat (5) tick();
        chk("drop_resp_count", resp_cores.size(), 1);
        chk("drop_dout", data_out[3*W +: W], 32'hFFFFFF8F);

        clear_log();
        set_op(2, 1'b1, 32'h180, 32'h77);
        request[2] = 1'b1;
        wait_resp(1, 20);
        tick();
        tick();
        set_op(1, 1'b0, 32'h24, 32'h0);
        request[1] = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        do_reset();

        set_op(0, 1'b0, 32'h4, 32'h0);
        set_op(3, 1'b0, 32'hC, 32'h0);
        request = 4'b1001;
        wait_resp(2, 30);
        chk("post_rst_dout0", data_out[0*W +: W], 32'hFFFFFFFB);
        tick();
        tick();

        do_reset();
        for (int c = 0; c < N; c++) begin
            set_op(c, 1'b1, 32'h300 + 32'(c), 32'hA0 + 32'(c));
        end
        request = 4'b1111;
        wait_resp(4, 40);
        for (int k = 1; k < resp_cyc.size(); k++) begin
            chk("contend_gap", resp_cyc[k] - resp_cyc[k-1], 3);
        end
        tick();
        chk("contend_busy_end", busy, 0);
        tick();

        clear_log();
        hold = 4'b1001;
        set_op(0, 1'b1, 32'h500, 32'h11);
        set_op(3, 1'b0, 32'h60, 32'h0);
        set_op(0, 1'b1, 32'h500, 32'h11);
        set_op(3, 1'b0, 32'h60, 32'h0);
        request[0] = 1'b1;
        tick();
        request[3] = 1'b1;
        wait_resp(4, 40);
        request = '0;
        hold    = '0;
        repeat (8) tick();
        chk("fair_count", resp_cores.size(), 4);
        chk("fair_dout3", data_out[3*W +: W], 32'hFFFFFF9F);
        chk("fair_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
